// File: rtl/tree_pkg.sv
// Shared types for the schema node tree and its transmit-side field id encoder.
package tree_pkg;

  localparam int DEF_FIELD_W = 8;
  localparam int DEF_DEPTH_W = 3;

  typedef enum logic [1:0] {
    TOK_LEAF  = 2'd0,
    TOK_OPEN  = 2'd1,
    TOK_CLOSE = 2'd2,
    TOK_END   = 2'd3
  } tok_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLOSE,
    ST_EMIT,
    ST_FLUSH
  } enc_state_e;

  typedef struct packed {
    logic [DEF_FIELD_W-1:0] field_id;
    logic [DEF_DEPTH_W-1:0] depth;
    logic                   is_parent;
    logic                   last;
  } node_rec_t;

endpackage

// File: rtl/id_stack.sv
// LIFO of open parent field ids; top_o is the most recently pushed id.
module id_stack #(
  parameter int FIELD_W   = 8,
  parameter int MAX_DEPTH = 8,
  parameter int SP_W      = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [FIELD_W-1:0] push_id_i,
  output logic [FIELD_W-1:0] top_o,
  output logic [SP_W-1:0]    sp_o
);

  localparam int IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [FIELD_W-1:0] mem [MAX_DEPTH];
  logic [SP_W-1:0]    sp_q;
  logic [SP_W-1:0]    sp_dec;

  assign sp_dec = sp_q - SP_W'(1);
  assign top_o  = mem[sp_dec[IDX_W-1:0]];
  assign sp_o   = sp_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sp_q <= '0;
    end else if (push_i) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop_i) begin
      sp_q <= sp_dec;
    end
  end

  // Entries are never read at or above sp, so storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[sp_q[IDX_W-1:0]] <= push_id_i;
    end
  end

  a_no_push_pop: assert property (@(posedge clk_i) disable iff (!reset_i) !(push_i && pop_i));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_i) pop_i |-> (sp_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_i) push_i |-> (sp_q != SP_W'(MAX_DEPTH)));

endmodule

// File: rtl/field_id_encoder.sv
// Serialises schema node records into OPEN/LEAF/CLOSE/END field id tokens.
module field_id_encoder
  import tree_pkg::*;
#(
  parameter int FIELD_W   = DEF_FIELD_W,
  parameter int DEPTH_W   = DEF_DEPTH_W,
  parameter int MAX_DEPTH = 2**DEPTH_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               node_valid_i,
  output logic               node_rdy_o,
  input  logic [FIELD_W-1:0] node_field_id_i,
  input  logic [DEPTH_W-1:0] node_depth_i,
  input  logic               node_is_parent_i,
  input  logic               node_last_i,
  output logic               tok_valid_o,
  input  logic               tok_rdy_i,
  output logic [1:0]         tok_kind_o,
  output logic [FIELD_W-1:0] tok_field_id_o,
  output logic [DEPTH_W-1:0] tok_depth_o,
  output logic [DEPTH_W:0]   depth_o,
  output logic               err_o
);

  localparam int SP_W = DEPTH_W + 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(MAX_DEPTH);

  enc_state_e         state_q;
  tok_kind_e          tok_kind_q;
  logic [FIELD_W-1:0] pend_id;
  logic [DEPTH_W-1:0] pend_depth;
  logic               pend_parent;
  logic               pend_last;

  logic [SP_W-1:0]    sp;
  logic [SP_W-1:0]    sp_dec;
  logic [SP_W-1:0]    node_depth_x;
  logic [FIELD_W-1:0] top_id;
  logic [FIELD_W-1:0] push_id;
  logic               slot_free;
  logic               accept;
  logic               node_err;
  logic               node_match;
  logic               push;
  logic               pop;

  assign slot_free    = !tok_valid_o || tok_rdy_i;
  assign node_rdy_o   = reset_i && (state_q == ST_IDLE) && slot_free;
  assign accept       = node_valid_i && node_rdy_o;
  assign node_depth_x = {1'b0, node_depth_i};
  assign sp_dec       = sp - SP_W'(1);
  assign node_err     = (node_depth_x > sp) ||
                        (node_is_parent_i && (node_depth_x == sp) && (sp == SP_MAX));
  assign node_match   = (node_depth_x == sp);

  assign push    = (accept && !node_err && node_match && node_is_parent_i) ||
                   ((state_q == ST_EMIT) && slot_free && pend_parent);
  assign push_id = (state_q == ST_EMIT) ? pend_id : node_field_id_i;
  assign pop     = slot_free && ((state_q == ST_CLOSE) || ((state_q == ST_FLUSH) && (sp != '0)));

  assign tok_kind_o = tok_kind_q;
  assign depth_o    = sp;

  id_stack #(
    .FIELD_W  (FIELD_W),
    .MAX_DEPTH(MAX_DEPTH),
    .SP_W     (SP_W)
  ) u_stack (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .push_i   (push),
    .pop_i    (pop),
    .push_id_i(push_id),
    .top_o    (top_id),
    .sp_o     (sp)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= ST_IDLE;
      tok_valid_o    <= 1'b0;
      tok_kind_q     <= TOK_LEAF;
      tok_field_id_o <= '0;
      tok_depth_o    <= '0;
      err_o          <= 1'b0;
      pend_id        <= '0;
      pend_depth     <= '0;
      pend_parent    <= 1'b0;
      pend_last      <= 1'b0;
    end else begin
      // A consumed token drops valid unless a new one is loaded below.
      if (tok_rdy_i) begin
        tok_valid_o <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (node_err) begin
              err_o <= 1'b1;
            end else if (node_match) begin
              tok_valid_o    <= 1'b1;
              tok_kind_q     <= node_is_parent_i ? TOK_OPEN : TOK_LEAF;
              tok_field_id_o <= node_field_id_i;
              tok_depth_o    <= node_depth_i;
              state_q        <= node_last_i ? ST_FLUSH : ST_IDLE;
            end else begin
              pend_id     <= node_field_id_i;
              pend_depth  <= node_depth_i;
              pend_parent <= node_is_parent_i;
              pend_last   <= node_last_i;
              state_q     <= ST_CLOSE;
            end
          end
        end
        ST_CLOSE: begin
          if (slot_free) begin
            tok_valid_o    <= 1'b1;
            tok_kind_q     <= TOK_CLOSE;
            tok_field_id_o <= top_id;
            tok_depth_o    <= sp_dec[DEPTH_W-1:0];
            if (sp_dec == {1'b0, pend_depth}) begin
              state_q <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (slot_free) begin
            tok_valid_o    <= 1'b1;
            tok_kind_q     <= pend_parent ? TOK_OPEN : TOK_LEAF;
            tok_field_id_o <= pend_id;
            tok_depth_o    <= pend_depth;
            state_q        <= pend_last ? ST_FLUSH : ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (slot_free) begin
            tok_valid_o <= 1'b1;
            if (sp != '0) begin
              tok_kind_q     <= TOK_CLOSE;
              tok_field_id_o <= top_id;
              tok_depth_o    <= sp_dec[DEPTH_W-1:0];
            end else begin
              tok_kind_q     <= TOK_END;
              tok_field_id_o <= '0;
              tok_depth_o    <= '0;
              state_q        <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_field_id_encoder.sv
// Directed self-checking bench for field_id_encoder (MAX_DEPTH=8, 4-bit depth field).
module tb_field_id_encoder;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       node_valid_i = 1'b0;
  logic       node_rdy_o;
  logic [7:0] node_field_id_i = '0;
  logic [3:0] node_depth_i = '0;
  logic       node_is_parent_i = 1'b0;
  logic       node_last_i = 1'b0;
  logic       tok_valid_o;
  logic       tok_rdy_i = 1'b1;
  logic [1:0] tok_kind_o;
  logic [7:0] tok_field_id_o;
  logic [3:0] tok_depth_o;
  logic [4:0] depth_o;
  logic       err_o;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [1:0] q_kind[$];
  logic [7:0] q_id[$];
  logic [3:0] q_dep[$];
  logic [4:0] q_sp[$];
  logic       q_rdy[$];
  int         q_cyc[$];

  logic       stall_prev = 1'b0;
  logic [1:0] stall_kind;
  logic [7:0] stall_id;
  logic [3:0] stall_dep;

  field_id_encoder #(
    .FIELD_W  (8),
    .DEPTH_W  (4),
    .MAX_DEPTH(8)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .node_valid_i    (node_valid_i),
    .node_rdy_o      (node_rdy_o),
    .node_field_id_i (node_field_id_i),
    .node_depth_i    (node_depth_i),
    .node_is_parent_i(node_is_parent_i),
    .node_last_i     (node_last_i),
    .tok_valid_o     (tok_valid_o),
    .tok_rdy_i       (tok_rdy_i),
    .tok_kind_o      (tok_kind_o),
    .tok_field_id_o  (tok_field_id_o),
    .tok_depth_o     (tok_depth_o),
    .depth_o         (depth_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  // Token log and hold check, sampled mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (stall_prev) begin
        checks++;
        if ({tok_valid_o, tok_kind_o, tok_field_id_o, tok_depth_o} !== {1'b1, stall_kind, stall_id, stall_dep})
          $display("[TB] FAIL stall_hold: got v=%0b k=%0d id=%0d d=%0d want v=1 k=%0d id=%0d d=%0d",
                   tok_valid_o, tok_kind_o, tok_field_id_o, tok_depth_o, stall_kind, stall_id, stall_dep);
        else passes++;
      end
      if (tok_valid_o && tok_rdy_i) begin
        q_kind.push_back(tok_kind_o);
        q_id.push_back(tok_field_id_o);
        q_dep.push_back(tok_depth_o);
        q_sp.push_back(depth_o);
        q_rdy.push_back(node_rdy_o);
        q_cyc.push_back(cyc);
      end
      stall_prev = tok_valid_o && !tok_rdy_i;
      stall_kind = tok_kind_o;
      stall_id   = tok_field_id_o;
      stall_dep  = tok_depth_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_log();
    q_kind.delete(); q_id.delete(); q_dep.delete();
    q_sp.delete(); q_rdy.delete(); q_cyc.delete();
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    node_valid_i = 1'b0;
    tok_rdy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_log();
  endtask

  task automatic send_node(input logic [7:0] id, input logic [3:0] d, input logic p, input logic l,
                           output int acc_cyc);
    node_valid_i = 1'b1;
    node_field_id_i = id;
    node_depth_i = d;
    node_is_parent_i = p;
    node_last_i = l;
    acc_cyc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (node_rdy_o) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    node_valid_i = 1'b0;
    checks++;
    if (acc_cyc < 0) $display("[TB] FAIL node_accept id=%0d: got no node_rdy_o within 100 cycles, want accept", id);
    else passes++;
  endtask

  task automatic wait_end(input string name);
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_i);
      if (q_kind.size() > 0 && q_kind[q_kind.size()-1] == 2'd3) begin
        ok = 1;
        break;
      end
    end
    #1;
    checks++;
    if (!ok) $display("[TB] FAIL %s_end_timeout: got no END token, want END within 300 cycles", name);
    else passes++;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    node_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({tok_valid_o, tok_kind_o, tok_field_id_o, tok_depth_o} !== 15'd0)
      $display("[TB] FAIL reset_tok: got v=%0b k=%0d id=%0d d=%0d want all 0",
               tok_valid_o, tok_kind_o, tok_field_id_o, tok_depth_o);
    else passes++;
    checks++;
    if (depth_o !== 5'd0) $display("[TB] FAIL reset_depth: got %0d want 0", depth_o);
    else passes++;
    checks++;
    if (err_o !== 1'b0) $display("[TB] FAIL reset_err: got %0b want 0", err_o);
    else passes++;
    checks++;
    if (node_rdy_o !== 1'b0) $display("[TB] FAIL reset_node_rdy: got %0b want 0", node_rdy_o);
    else passes++;
    do_reset();
  endtask

  task automatic test_flat();
    int a0, a1;
    logic [1:0] ek[3] = '{2'd0, 2'd0, 2'd3};
    logic [7:0] ei[3] = '{8'd5, 8'd7, 8'd0};
    clear_log();
    send_node(8'd5, 4'd0, 1'b0, 1'b0, a0);
    send_node(8'd7, 4'd0, 1'b0, 1'b1, a1);
    wait_end("flat");
    checks++;
    if (q_kind.size() !== 3) $display("[TB] FAIL flat_count: got %0d tokens want 3", q_kind.size());
    else passes++;
    for (int i = 0; i < 3 && i < q_kind.size(); i++) begin
      checks++;
      if ({q_kind[i], q_id[i], q_dep[i], q_sp[i]} !== {ek[i], ei[i], 4'd0, 5'd0})
        $display("[TB] FAIL flat_tok%0d: got k=%0d id=%0d d=%0d sp=%0d want k=%0d id=%0d d=0 sp=0",
                 i, q_kind[i], q_id[i], q_dep[i], q_sp[i], ek[i], ei[i]);
      else passes++;
    end
    if (q_cyc.size() >= 3) begin
      checks++;
      if (q_cyc[0] !== a0 + 1) $display("[TB] FAIL flat_latency: got token cycle %0d want %0d", q_cyc[0], a0 + 1);
      else passes++;
      checks++;
      if ((q_cyc[1] !== q_cyc[0] + 1) || (q_cyc[2] !== q_cyc[1] + 1))
        $display("[TB] FAIL flat_rate: got cycles %0d,%0d,%0d want consecutive", q_cyc[0], q_cyc[1], q_cyc[2]);
      else passes++;
    end
  endtask

  task automatic test_nesting(input string name);
    int a;
    logic [1:0] ek[7] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [7:0] ei[7] = '{8'd3, 8'd4, 8'd9, 8'd4, 8'd3, 8'd6, 8'd0};
    logic [3:0] ed[7] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    send_node(8'd3, 4'd0, 1'b1, 1'b0, a);
    send_node(8'd4, 4'd1, 1'b1, 1'b0, a);
    send_node(8'd9, 4'd2, 1'b0, 1'b0, a);
    send_node(8'd6, 4'd0, 1'b0, 1'b1, a);
    wait_end(name);
    checks++;
    if (q_kind.size() !== 7) $display("[TB] FAIL %s_count: got %0d tokens want 7", name, q_kind.size());
    else passes++;
    for (int i = 0; i < 7 && i < q_kind.size(); i++) begin
      checks++;
      if ({q_kind[i], q_id[i], q_dep[i]} !== {ek[i], ei[i], ed[i]})
        $display("[TB] FAIL %s_tok%0d: got k=%0d id=%0d d=%0d want k=%0d id=%0d d=%0d",
                 name, i, q_kind[i], q_id[i], q_dep[i], ek[i], ei[i], ed[i]);
      else passes++;
    end
    for (int i = 3; i < 5 && i < q_rdy.size(); i++) begin
      checks++;
      if (q_rdy[i] !== 1'b0) $display("[TB] FAIL %s_rdy_close%0d: got node_rdy_o=%0b want 0", name, i, q_rdy[i]);
      else passes++;
    end
    checks++;
    if (depth_o !== 5'd0) $display("[TB] FAIL %s_depth_end: got %0d want 0", name, depth_o);
    else passes++;
  endtask

  task automatic test_flush_on_last();
    int a;
    logic [1:0] ek[6] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    logic [7:0] ei[6] = '{8'd3, 8'd4, 8'd9, 8'd4, 8'd3, 8'd0};
    logic [3:0] ed[6] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd0};
    clear_log();
    send_node(8'd3, 4'd0, 1'b1, 1'b0, a);
    send_node(8'd4, 4'd1, 1'b1, 1'b0, a);
    send_node(8'd9, 4'd2, 1'b0, 1'b1, a);
    wait_end("flush");
    checks++;
    if (q_kind.size() !== 6) $display("[TB] FAIL flush_count: got %0d tokens want 6", q_kind.size());
    else passes++;
    for (int i = 0; i < 6 && i < q_kind.size(); i++) begin
      checks++;
      if ({q_kind[i], q_id[i], q_dep[i]} !== {ek[i], ei[i], ed[i]})
        $display("[TB] FAIL flush_tok%0d: got k=%0d id=%0d d=%0d want k=%0d id=%0d d=%0d",
                 i, q_kind[i], q_id[i], q_dep[i], ek[i], ei[i], ed[i]);
      else passes++;
    end
    checks++;
    if (depth_o !== 5'd0) $display("[TB] FAIL flush_depth_end: got %0d want 0", depth_o);
    else passes++;
  endtask

  task automatic test_back_to_back_backpressure();
    clear_log();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk_i);
          #1;
          tok_rdy_i = (k >= 4 && k < 9) ? 1'b0 : ((k % 2) == 0);
        end
        tok_rdy_i = 1'b1;
      end
      test_nesting("bp");
    join
    tok_rdy_i = 1'b1;
  endtask

  task automatic test_depth_error();
    int a;
    clear_log();
    send_node(8'd2, 4'd2, 1'b0, 1'b0, a);
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (err_o !== 1'b1) $display("[TB] FAIL deperr_err: got %0b want 1", err_o);
    else passes++;
    checks++;
    if (q_kind.size() !== 0) $display("[TB] FAIL deperr_no_tok: got %0d tokens want 0", q_kind.size());
    else passes++;
    send_node(8'd8, 4'd0, 1'b0, 1'b1, a);
    wait_end("deperr");
    checks++;
    if (q_kind.size() !== 2 || {q_kind[0], q_id[0], q_dep[0]} !== {2'd0, 8'd8, 4'd0})
      $display("[TB] FAIL deperr_next: got %0d tokens first k=%0d id=%0d want 2 tokens first LEAF id=8 d=0",
               q_kind.size(), q_kind.size() > 0 ? q_kind[0] : 2'd0, q_kind.size() > 0 ? q_id[0] : 8'd0);
    else passes++;
    checks++;
    if (err_o !== 1'b1) $display("[TB] FAIL deperr_sticky: got %0b want 1", err_o);
    else passes++;
  endtask

  task automatic test_overflow();
    int a;
    do_reset();
    for (int i = 0; i < 9; i++) send_node(8'(10 + i), 4'(i), 1'b1, 1'b0, a);
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (err_o !== 1'b1) $display("[TB] FAIL ovf_err: got %0b want 1", err_o);
    else passes++;
    checks++;
    if (depth_o !== 5'd8) $display("[TB] FAIL ovf_depth: got %0d want 8", depth_o);
    else passes++;
    checks++;
    if (q_kind.size() !== 8) $display("[TB] FAIL ovf_count: got %0d tokens want 8", q_kind.size());
    else passes++;
    if (q_kind.size() >= 8) begin
      checks++;
      if ({q_kind[7], q_id[7], q_dep[7]} !== {2'd1, 8'd17, 4'd7})
        $display("[TB] FAIL ovf_last_open: got k=%0d id=%0d d=%0d want k=1 id=17 d=7", q_kind[7], q_id[7], q_dep[7]);
      else passes++;
    end
    do_reset();
  endtask

  task automatic test_reset_mid_close();
    int a;
    send_node(8'd1, 4'd3, 1'b0, 1'b0, a);
    send_node(8'd3, 4'd0, 1'b1, 1'b0, a);
    send_node(8'd4, 4'd1, 1'b1, 1'b0, a);
    send_node(8'd9, 4'd2, 1'b0, 1'b0, a);
    send_node(8'd6, 4'd0, 1'b0, 1'b1, a);
    tok_rdy_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({tok_valid_o, tok_kind_o, tok_field_id_o, err_o} !== {1'b1, 2'd2, 8'd4, 1'b1})
      $display("[TB] FAIL rst_pre: got v=%0b k=%0d id=%0d err=%0b want v=1 k=2 id=4 err=1",
               tok_valid_o, tok_kind_o, tok_field_id_o, err_o);
    else passes++;
    #2;
    reset_i = 1'b0;
    #1;
    checks++;
    if ({tok_valid_o, depth_o, err_o, node_rdy_o} !== 8'd0)
      $display("[TB] FAIL rst_async: got v=%0b sp=%0d err=%0b rdy=%0b want all 0",
               tok_valid_o, depth_o, err_o, node_rdy_o);
    else passes++;
    do_reset();
    send_node(8'd5, 4'd0, 1'b0, 1'b0, a);
    send_node(8'd7, 4'd0, 1'b0, 1'b1, a);
    wait_end("rst");
    checks++;
    if (q_kind.size() !== 3 || {q_kind[0], q_id[0], q_kind[1], q_id[1], q_kind[2], q_id[2]} !==
        {2'd0, 8'd5, 2'd0, 8'd7, 2'd3, 8'd0})
      $display("[TB] FAIL rst_fresh: got %0d tokens want LEAF5 LEAF7 END", q_kind.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_flat();
    clear_log();
    test_nesting("nest");
    test_flush_on_last();
    test_back_to_back_backpressure();
    test_depth_error();
    test_overflow();
    test_reset_mid_close();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/field_id_encoder.md
Name: field_id_encoder

Overview:
- Transmit-side counterpart of the node tree walker.
- Accepts a stream of schema node records (field id, tree depth, parent/leaf, end-of-message) and serialises it into a flat field-identifier token stream.
- Emits explicit OPEN/LEAF/CLOSE/END tokens so the receiving node tree can advance and retreat its node pointer.
- Keeps a stack of open parent field ids so closing tokens carry the id of the group being closed.

Parameters:
- FIELD_W, 8, width of a field identifier.
- DEPTH_W, 3, width of node depth; MAX_DEPTH = 2**DEPTH_W.
- MAX_DEPTH, 8, stack entries (maximum number of simultaneously open parents).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- node_valid_i  in  1  node record valid.
- node_rdy_o  out  1  encoder accepts node record this cycle.
- node_field_id_i  in  FIELD_W  field identifier of node.
- node_depth_i  in  DEPTH_W  depth of node (root children = 0).
- node_is_parent_i  in  1  node opens a sub-group.
- node_last_i  in  1  last node of message.
- tok_valid_o  out  1  token valid.
- tok_rdy_i  in  1  downstream accepts token.
- tok_kind_o  out  2  0 LEAF, 1 OPEN, 2 CLOSE, 3 END.
- tok_field_id_o  out  FIELD_W  field id carried by token (0 for END).
- tok_depth_o  out  DEPTH_W  depth at which token applies.
- depth_o  out  DEPTH_W+1  current stack pointer sp (number of open parents).
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async assert, sync release): tok_valid_o=0, tok_kind_o=0, tok_field_id_o=0, tok_depth_o=0, sp=0, err_o=0, state=IDLE, node_rdy_o=0 while reset asserted. Any in-flight token or pending node is discarded.
- Output register, single entry: slot_free = !tok_valid_o || tok_rdy_i.
  - Token fields are held stable while tok_valid_o && !tok_rdy_i.
  - tok_valid_o is cleared on handshake when no new token is loaded that cycle.
- FSM states: IDLE, CLOSE, EMIT, FLUSH.
- IDLE:
  - node_rdy_o = slot_free. Accept = node_valid_i && node_rdy_o.
  - Error: node_depth_i > sp, or (node_is_parent_i && node_depth_i == sp && sp == MAX_DEPTH).
    - Set err_o, drop node, emit nothing, stay IDLE.
    - Applies even with node_last_i.
  - Match: node_depth_i == sp.
    - Load token: OPEN if parent, else LEAF, with field id and depth sp.
    - If parent: push field id, sp+1.
    - Token is visible the cycle after accept (latency 1).
    - Next state FLUSH if node_last_i, else IDLE.
  - Shallower: node_depth_i < sp. Latch node into pending register, go CLOSE. No token this cycle.
- CLOSE:
  - node_rdy_o=0. Each cycle with slot_free: load CLOSE token with stack[sp-1], depth sp-1; sp-1.
  - When the new sp equals the pending depth, go EMIT.
  - For d<sp, exactly sp-d CLOSE tokens are emitted.
- EMIT:
  - node_rdy_o=0. When slot_free: load pending OPEN/LEAF at depth sp; push if parent.
  - Overflow is impossible here because sp was reduced.
  - Next state FLUSH if pending last, else IDLE.
- FLUSH:
  - node_rdy_o=0. While sp>0 and slot_free: emit CLOSE(stack[sp-1]) and decrement sp.
  - When sp==0 and slot_free: emit END (field id 0, depth 0), go IDLE.
  - A message with zero open parents emits END directly after the last node token.
- Throughput: one token per cycle under continuous tok_rdy_i=1; node acceptance stalls during CLOSE/EMIT/FLUSH.
- tok_rdy_i low for any duration: no token lost or duplicated; sp and state advance only on slot_free.
- err_o clears only on reset. Stack contents are not reset; entries are only read below sp.

Decomposition:
- tree_pkg holds:
  - typedef tok_kind_e (LEAF/OPEN/CLOSE/END);
  - typedef enc_state_e;
  - node record struct {field_id, depth, is_parent, last};
  - FIELD_W/DEPTH_W defaults shared with the node tree.
- Sub-module id_stack: MAX_DEPTH x FIELD_W LIFO exposing push, pop, top and sp.
  - Push and pop are never asserted together.
  - Pop at sp==0 and push at sp==MAX_DEPTH are guarded by the FSM; assertions are added in id_stack.

Test Plan:
- Flat message, tok_rdy=1: nodes (id 5,d0,leaf),(id 7,d0,leaf,last) -> LEAF5@0, LEAF7@0, END; one token per cycle, latency 1, depth_o stays 0.
- Nesting: (3,d0,parent),(4,d1,parent),(9,d2,leaf),(6,d0,leaf,last) -> OPEN3, OPEN4, LEAF9@2, CLOSE4@1, CLOSE3@0, LEAF6@0, END; node_rdy_o low during the two CLOSEs.
- Flush on last: (3,d0,parent),(4,d1,parent),(9,d2,leaf,last) -> ..., LEAF9, CLOSE4, CLOSE3, END; depth_o returns to 0.
- Backpressure: repeat the nesting case with tok_rdy_i toggled 1/0 and a 5-cycle low window -> identical token sequence, fields stable while stalled, no drops.
- Errors:
  - node depth 2 with sp=0 -> err_o=1, no token, next valid node still encoded.
  - 9 nested parents with MAX_DEPTH=8 -> err_o=1 on the 9th, depth_o=8.
- Reset mid-operation: assert reset_i during CLOSE with tok_valid_o=1 -> tok_valid_o=0, depth_o=0, err_o=0 immediately; a fresh message after release encodes correctly.
